// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_t;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;

endpackage

// File: rtl/mem_arb_pick.sv
// Next-grant decision for the arbiter plus the saturating count of consecutive
// data grants taken while a fetch was waiting.
module mem_arb_pick #(
  parameter int unsigned MAX_DRUN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic i_valid,
  input  logic d_valid,
  output logic grant_i,
  output logic grant_d
);

  localparam int unsigned DW = $clog2(MAX_DRUN + 1);
  localparam logic [DW-1:0] DRUN_MAX = DW'(MAX_DRUN);

  logic [DW-1:0] drun;

  always_comb begin
    grant_d = idle && d_valid && !(i_valid && (drun == DRUN_MAX));
    grant_i = idle && !grant_d && i_valid;
  end

  // Only grants that actually bypass a waiting fetch advance the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      drun <= '0;
    end else if (grant_d) begin
      if (i_valid) begin
        drun <= (drun == DRUN_MAX) ? drun : drun + DW'(1);
      end else begin
        drun <= '0;
      end
    end else if (grant_i) begin
      drun <= '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one valid/ready memory bus between instruction fetch (I) and the
// load/store unit (D); data has priority, bounded so fetch always progresses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DRUN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb
);

  arb_state_t state;
  logic       grant_i;
  logic       grant_d;

  mem_arb_pick #(
    .MAX_DRUN(MAX_DRUN)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .idle   (state == ARB_IDLE),
    .i_valid(i_valid),
    .d_valid(d_valid),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );

  // A granted requester dropping valid aborts the cycle just like completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_d) begin
            state <= ARB_GNT_D;
          end else if (grant_i) begin
            state <= ARB_GNT_I;
          end
        end
        ARB_GNT_I: if (!i_valid || mem_ready) state <= ARB_IDLE;
        ARB_GNT_D: if (!d_valid || mem_ready) state <= ARB_IDLE;
        default:   state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = WSTRB_NONE;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    case (state)
      ARB_GNT_I: begin
        mem_valid = i_valid;
        mem_addr  = i_addr;
        i_ready   = mem_ready && i_valid;
        i_rdata   = mem_rdata;
        d_rdata   = mem_rdata;
      end
      ARB_GNT_D: begin
        mem_valid = d_valid;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_wstrb = d_wstrb;
        d_ready   = mem_ready && d_valid;
        i_rdata   = mem_rdata;
        d_rdata   = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of request mixes plus hand-written
// latency, starvation, reset and abort sequences.
module tb_mem_arbiter;

  localparam int unsigned MAX_DRUN = 4;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_valid;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  mem_arbiter #(
    .MAX_DRUN(MAX_DRUN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .i_addr   (i_addr),
    .i_ready  (i_ready),
    .i_rdata  (i_rdata),
    .d_valid  (d_valid),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_wstrb  (d_wstrb),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    bit          i_req;
    logic [31:0] i_addr;
    bit          d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    int unsigned lat;
    int unsigned n;
    logic [1:0]  order;   // bit k set: k-th completion is a data transaction
  } vec_t;

  req_t        i_q[$];
  req_t        d_q[$];
  exp_t        i_exp[$];
  exp_t        d_exp[$];
  logic        log_q[$];
  int          n_vec;
  int          n_err;
  bit          i_done;
  bit          d_done;
  bit          prev_hs;
  bit          seen_valid;
  bit          mem_auto;
  int unsigned lat;
  int unsigned lat_cnt;
  vec_t        vecs[7];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic observe();
    exp_t e;
    if (mem_valid) seen_valid = 1'b1;
    if (prev_hs) check_b("bubble_after_done", mem_valid, 1'b0);
    prev_hs = 1'b0;
    if (i_ready || d_ready) begin
      check_b("ready_needs_mem_ready", mem_ready, 1'b1);
      check_b("ready_needs_mem_valid", mem_valid, 1'b1);
      check_b("ready_exclusive", i_ready & d_ready, 1'b0);
    end
    if (mem_valid && mem_ready) begin
      prev_hs = 1'b1;
      if (d_ready) begin
        if (d_exp.size() == 0) begin
          fail_now("d_ready_unexpected");
        end else begin
          e = d_exp.pop_front();
          check("d_mem_addr", mem_addr, e.addr);
          check("d_mem_wdata", mem_wdata, e.wdata);
          check("d_mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
          check("d_rdata", d_rdata, e.rdata);
          log_q.push_back(1'b1);
        end
        d_done = 1'b1;
      end else if (i_ready) begin
        if (i_exp.size() == 0) begin
          fail_now("i_ready_unexpected");
        end else begin
          e = i_exp.pop_front();
          check("i_mem_addr", mem_addr, e.addr);
          check("i_mem_wdata", mem_wdata, e.wdata);
          check("i_mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
          check("i_rdata", i_rdata, e.rdata);
          log_q.push_back(1'b0);
        end
        i_done = 1'b1;
      end else begin
        fail_now("handshake_without_ready");
      end
    end
  endtask

  task automatic update();
    req_t r;
    if (i_done) begin
      i_valid = 1'b0;
      i_done  = 1'b0;
    end
    if (d_done) begin
      d_valid = 1'b0;
      d_done  = 1'b0;
    end
    if (!i_valid && i_q.size() > 0) begin
      r = i_q.pop_front();
      i_valid = 1'b1;
      i_addr  = r.addr;
      i_exp.push_back('{addr: r.addr, wdata: 32'h0, wstrb: 4'h0, rdata: mem_data(r.addr)});
    end
    if (!d_valid && d_q.size() > 0) begin
      r = d_q.pop_front();
      d_valid = 1'b1;
      d_addr  = r.addr;
      d_wdata = r.wdata;
      d_wstrb = r.wstrb;
      d_exp.push_back('{addr: r.addr, wdata: r.wdata, wstrb: r.wstrb, rdata: mem_data(r.addr)});
    end
  endtask

  task automatic mem_model();
    mem_ready = 1'b0;
    if (mem_auto && mem_valid) begin
      lat_cnt++;
      if (lat_cnt >= lat) begin
        mem_ready = 1'b1;
        mem_rdata = mem_data(mem_addr);
        lat_cnt   = 0;
      end
    end else begin
      lat_cnt = 0;
    end
  endtask

  task automatic cycle_tail();
    @(posedge clk);
    #1;
    update();
    #1;
    mem_model();
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    cycle_tail();
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    while ((i_q.size() > 0 || d_q.size() > 0 || i_valid || d_valid ||
            i_exp.size() > 0 || d_exp.size() > 0) && k < budget) begin
      cycle();
      k++;
    end
    if (k >= budget) begin
      n_vec++;
      n_err++;
      $display("FAIL run_timeout: got %0d cycles expected fewer than %0d", k, budget);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    i_valid   = 1'b0;
    d_valid   = 1'b0;
    mem_ready = 1'b0;
    i_q.delete();
    d_q.delete();
    i_exp.delete();
    d_exp.delete();
    log_q.delete();
    i_done     = 1'b0;
    d_done     = 1'b0;
    prev_hs    = 1'b0;
    seen_valid = 1'b0;
    lat_cnt    = 0;
    mem_auto   = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic wait_grant(input string name);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      observe();
      if (mem_valid) break;
      cycle_tail();
    end
    check_b(name, mem_valid, 1'b1);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    i_addr    = '0;
    d_addr    = '0;
    d_wdata   = '0;
    d_wstrb   = '0;
    mem_rdata = '0;
    lat       = 1;

    vecs[0] = '{1'b1, 32'h100, 1'b0, 32'h0,    32'h0,        4'h0,    2, 1, 2'b00};
    vecs[1] = '{1'b0, 32'h0,   1'b1, 32'h2000, 32'h0,        4'h0,    1, 1, 2'b01};
    vecs[2] = '{1'b1, 32'h100, 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF,    1, 2, 2'b01};
    vecs[3] = '{1'b1, 32'h80,  1'b1, 32'h3004, 32'h0,        4'h0,    3, 2, 2'b01};
    vecs[4] = '{1'b0, 32'h0,   1'b0, 32'h0,    32'h0,        4'h0,    1, 0, 2'b00};
    vecs[5] = '{1'b1, 32'h40,  1'b0, 32'h0,    32'h0,        4'h0,    1, 1, 2'b00};
    vecs[6] = '{1'b0, 32'h0,   1'b1, 32'h44,   32'h11223344, 4'b0011, 2, 1, 2'b01};

    // Reset state with no requests
    do_reset();
    repeat (4) begin
      @(negedge clk);
      check_b("rst_mem_valid", mem_valid, 1'b0);
      check_b("rst_i_ready", i_ready, 1'b0);
      check_b("rst_d_ready", d_ready, 1'b0);
      check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_i_rdata", i_rdata, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);
      @(posedge clk);
      #1;
    end

    // Table of request mixes, each from a fresh reset
    foreach (vecs[v]) begin
      do_reset();
      lat = vecs[v].lat;
      if (vecs[v].i_req) i_q.push_back('{addr: vecs[v].i_addr, wdata: 32'h0, wstrb: 4'h0});
      if (vecs[v].d_req) d_q.push_back('{addr: vecs[v].d_addr, wdata: vecs[v].d_wdata,
                                         wstrb: vecs[v].d_wstrb});
      run_until_idle(40);
      repeat (3) cycle();
      check("vec_completions", 32'(log_q.size()), 32'(vecs[v].n));
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        if (k < log_q.size()) check_b("vec_order", log_q[k], vecs[v].order[k]);
      end
      if (vecs[v].n == 0) check_b("vec_idle_no_valid", seen_valid, 1'b0);
    end

    // Fetch: one-cycle arbitration latency, memory ready after 2 cycles
    do_reset();
    lat = 2;
    i_q.push_back('{addr: 32'h100, wdata: 32'h0, wstrb: 4'h0});
    cycle();
    @(negedge clk);
    check_b("fetch_latency_before", mem_valid, 1'b0);
    observe();
    cycle_tail();
    @(negedge clk);
    check_b("fetch_mem_valid", mem_valid, 1'b1);
    check_b("fetch_no_early_ready", i_ready, 1'b0);
    check("fetch_wstrb", 32'(mem_wstrb), 32'h0);
    observe();
    cycle_tail();
    @(negedge clk);
    check_b("fetch_i_ready", i_ready, 1'b1);
    check("fetch_i_rdata", i_rdata, 32'h13);
    observe();
    cycle_tail();
    cycle();

    // Continuous data traffic with a fetch pending: bounded D run
    do_reset();
    lat = 1;
    for (int k = 0; k < 6; k++) begin
      d_q.push_back('{addr: 32'h1000 + 32'(4 * k), wdata: 32'h0, wstrb: 4'h0});
    end
    i_q.push_back('{addr: 32'h200, wdata: 32'h0, wstrb: 4'h0});
    run_until_idle(150);
    check("starve_completions", 32'(log_q.size()), 32'd7);
    for (int k = 0; k < 7; k++) begin
      if (k < log_q.size()) check_b("starve_order", log_q[k], (k == MAX_DRUN) ? 1'b0 : 1'b1);
    end
    log_q.delete();
    i_q.push_back('{addr: 32'h204, wdata: 32'h0, wstrb: 4'h0});
    d_q.push_back('{addr: 32'h1100, wdata: 32'h0, wstrb: 4'h0});
    run_until_idle(40);
    check("drun_clear_completions", 32'(log_q.size()), 32'd2);
    if (log_q.size() > 0) check_b("drun_clear_d_first", log_q[0], 1'b1);

    // Reset in GNT_D with a late mem_ready
    do_reset();
    mem_auto = 1'b0;
    d_q.push_back('{addr: 32'h3000, wdata: 32'hCAFEF00D, wstrb: 4'hF});
    wait_grant("rstmid_grant");
    check("rstmid_addr", mem_addr, 32'h3000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h5555AAAA;
    #1;
    @(negedge clk);
    check_b("rstmid_mem_valid", mem_valid, 1'b0);
    check_b("rstmid_no_d_ready", d_ready, 1'b0);
    observe();
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check_b("rstmid_regrant", mem_valid, 1'b1);
    check_b("rstmid_regrant_no_ready", d_ready, 1'b0);
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    d_exp.delete();
    mem_auto = 1'b1;
    repeat (3) cycle();

    // Granted data request abandoned while a fetch waits
    do_reset();
    mem_auto = 1'b0;
    i_q.push_back('{addr: 32'h300, wdata: 32'h0, wstrb: 4'h0});
    d_q.push_back('{addr: 32'h4000, wdata: 32'h0, wstrb: 4'h0});
    wait_grant("abort_grant");
    check("abort_d_first", mem_addr, 32'h4000);
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    d_exp.delete();
    #1;
    check_b("abort_same_cycle", mem_valid, 1'b0);
    @(negedge clk);
    check_b("abort_no_ready", d_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_b("abort_idle", mem_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_b("abort_i_granted", mem_valid, 1'b1);
    check("abort_i_addr", mem_addr, 32'h300);
    mem_auto = 1'b1;
    lat = 1;
    log_q.delete();
    cycle_tail();
    run_until_idle(20);
    check("abort_i_completions", 32'(log_q.size()), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time limit expected finish");
    $fatal(1, "timeout");
  end

endmodule
